persiana_planta: RTL
====================

# persiana_planta

Behavioural plant model of the motorised blind: the opposite end of the motor/limit-switch interface driven by the blind controller. It consumes the `subir`/`bajar` motor commands, tracks blind position with a step counter, and produces the `Ssup`/`Smed`/`Sinf` limit-sensor signals that the controller reads back. It closes the loop in simulation and on-chip self-test, and flags illegal command combinations.

## Interface
- `TRAVEL`, 100: number of steps from fully closed (0) to fully open (`TRAVEL`); range 2..255.
- `MID`, 50: step position that asserts `Smed`; 0 < `MID` < `TRAVEL`.
- `PRESCALE`, 4: clock cycles per position step; ≥1.
- `REV_DEAD`, 8: dead-time cycles inserted on a direction reversal; ≥1.
- `POS_INI`, 0: position loaded at reset.

- `Reloj` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `subir` in 1: motor raise command.
- `bajar` in 1: motor lower command.
- `Ssup` out 1: upper limit, high iff `pos == TRAVEL`.
- `Smed` out 1: middle sensor, high iff `pos == MID`.
- `Sinf` out 1: lower limit, high iff `pos == 0`.
- `pos` out 8: current position in steps.
- `moving` out 1: high in SUBIENDO/BAJANDO while not at the limit in the direction of travel.
- `fault` out 1: high in FALLA.

## Operation
- States:
  - PARADA: idle.
  - SUBIENDO: raising.
  - BAJANDO: lowering.
  - ESPERA: reversal dead time.
  - FALLA: illegal command.
- FALLA rule: `subir & bajar` sampled high sends any state to FALLA on the next edge. This rule has priority over all others.
  - FALLA holds `pos` and stays while both commands are high.
  - FALLA exits to PARADA on the first cycle both commands are low. A single command alone does not exit FALLA.
- From PARADA:
  - `subir` only → SUBIENDO.
  - `bajar` only → BAJANDO.
  - Neither → stay.
- From SUBIENDO or BAJANDO:
  - Neither command → PARADA.
  - Same command held → stay.
  - Opposite command only → ESPERA, with the new direction latched.
- ESPERA counts `REV_DEAD` cycles, then enters the latched direction.
  - If the latched command drops during ESPERA → PARADA.
  - If the original command returns during ESPERA → PARADA.
- Stepping: a prescale counter clears on every state entry. While in SUBIENDO/BAJANDO, one step occurs every `PRESCALE` cycles.
  - Each step does `pos ± 1`, saturating at 0 and `TRAVEL`.
  - At saturation the state is held, `pos` is frozen and `moving` goes low. There is no wrap-around.
- Sensors are a combinational decode of the registered `pos`. When `REBOTE` is compiled out, they have no glitches.

## Timing
- Reset values:
  - State PARADA.
  - `pos = POS_INI`.
  - `moving = 0`, `fault = 0`.
  - Sensors decoded from `POS_INI`.
  - All counters 0.
- The state changes on the edge after the command is sampled.
- The first step lands `PRESCALE` cycles after entering SUBIENDO/BAJANDO.
- Sensor latency:
  - Sensors change in the same cycle `pos` changes.
  - From command to first `pos` change: 1 + `PRESCALE` cycles.
- A reversal costs 1 + `REV_DEAD` cycles before the new direction state is entered. The first step in the new direction follows `PRESCALE` cycles after that.
- When reset is asserted mid-move, outputs go to reset values immediately. No step is lost to a partial prescale on the next move, because the prescaler restarts.

## Configuration
- `PERSIANA_REBOTE_EN` defined: limit-switch bounce emulation is enabled.
  - When `pos` reaches 0 or `TRAVEL`, the matching sensor output toggles each cycle for 3 cycles, then is high steadily. The pattern is 1,0,1, then 1.
  - `Smed` never bounces.
- `PERSIANA_REBOTE_EN` undefined: sensors are the clean decode with no bounce logic.

## Structure
- Shared package `persiana_pkg`:
  - State enum `estado_planta_t`: PARADA, SUBIENDO, BAJANDO, ESPERA, FALLA.
  - Position width constant `POS_W = 8`.
  - Bounce length constant `REBOTE_LEN = 3`.
- Sub-module `planta_tick`: prescale counter with a synchronous clear input and a one-cycle `tick` output every `PRESCALE` cycles.

## Test plan
- Reset with `POS_INI=0` → `pos=0`, `Sinf=1`, `Ssup=0`, `moving=0`, `fault=0`.
- `subir` held from `pos=0` with `PRESCALE=4` → first `pos=1` at cycle 5. `Smed=1` at `pos=50` only. `Ssup=1` at `pos=100`, then `moving=0` and `pos` stays 100.
- From `pos=30` moving up, switch to `bajar` only → ESPERA for 8 cycles. `pos` is 30 throughout. BAJANDO is entered, and `pos=29` arrives 4 cycles later.
- `subir=bajar=1` at `pos=40` → `fault=1` next cycle and `pos` stays 40. Dropping to `subir` only keeps FALLA. Both low → PARADA and `fault=0`.
- Reset pulse mid-travel at `pos=70` → `pos` goes to 0 asynchronously. A new `subir` gives its first step after a full 1+4 cycles.
- `PERSIANA_REBOTE_EN` defined, lowering to 0 → `Sinf` pattern 1,0,1, then steady 1.

Source files
------------

// File: rtl/persiana_pkg.sv
// Shared types and constants for the motorised-blind plant model.
package persiana_pkg;

  localparam int POS_W      = 8;
  localparam int REBOTE_LEN = 3;

  typedef enum logic [2:0] {
    PARADA   = 3'd0,
    SUBIENDO = 3'd1,
    BAJANDO  = 3'd2,
    ESPERA   = 3'd3,
    FALLA    = 3'd4
  } estado_planta_t;

  // Sensor level during a bounce phase: phase 0 is the settled level, odd phases high, even low
  function automatic logic rebote_nivel(input logic [1:0] fase);
    rebote_nivel = (fase == 2'd0) ? 1'b1 : fase[0];
  endfunction

endpackage

// File: rtl/persiana_planta_tick.sv
// planta_tick: prescale counter giving a one-cycle tick every PRESCALE enabled cycles.
module planta_tick #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CW-1:0] cnt_r;

  assign tick = en & (cnt_r == CW'(PRESCALE - 1));

  // Count enabled cycles, wrapping on tick; clear wins so every new state starts a full period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= CW'(0);
    end else if (clr) begin
      cnt_r <= CW'(0);
    end else if (tick) begin
      cnt_r <= CW'(0);
    end else if (en) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/persiana_planta.sv
// persiana_planta: blind plant model turning subir/bajar into position and limit sensors.
// Define PERSIANA_REBOTE_EN to emulate limit-switch bounce on Ssup/Sinf.
module persiana_planta
  import persiana_pkg::*;
#(
  parameter int TRAVEL   = 100,
  parameter int MID      = 50,
  parameter int PRESCALE = 4,
  parameter int REV_DEAD = 8,
  parameter int POS_INI  = 0
) (
  input  logic             Reloj,
  input  logic             reset,
  input  logic             subir,
  input  logic             bajar,
  output logic             Ssup,
  output logic             Smed,
  output logic             Sinf,
  output logic [POS_W-1:0] pos,
  output logic             moving,
  output logic             fault
);

  localparam logic [POS_W-1:0] TOPE  = POS_W'(TRAVEL);
  localparam logic [POS_W-1:0] MEDIO = POS_W'(MID);
  localparam logic [POS_W-1:0] INI   = POS_W'(POS_INI);
  localparam logic [POS_W-1:0] CERO  = POS_W'(0);
  localparam int               DW    = $clog2(REV_DEAD + 1);

  estado_planta_t   estado_r, estado_nxt_s;
  logic             dir_r, dir_nxt_s;
  logic [DW-1:0]    dead_r, dead_nxt_s;
  logic [POS_W-1:0] pos_r, pos_nxt_s;
  logic             ambos_s, lat_s, tick_s, clr_s, en_s;
  logic             moving_r, fault_r, ssup_r, smed_r, sinf_r;
  logic             moving_nxt_s, ssup_nxt_s, sinf_nxt_s;

  assign ambos_s = subir & bajar;
  assign lat_s   = dir_r ? subir : bajar;
  assign en_s    = (estado_r == SUBIENDO) || (estado_r == BAJANDO);
  assign clr_s   = (estado_nxt_s != estado_r);

  planta_tick #(.PRESCALE(PRESCALE)) u_tick (
    .clk  (Reloj),
    .rst_n(reset),
    .clr  (clr_s),
    .en   (en_s),
    .tick (tick_s)
  );

  // Next state; dir_r holds the direction to resume after the reversal dead time
  always_comb begin
    estado_nxt_s = estado_r;
    dir_nxt_s    = dir_r;
    dead_nxt_s   = DW'(0);
    if (ambos_s) begin
      estado_nxt_s = FALLA;
    end else begin
      case (estado_r)
        PARADA: begin
          if (subir)      estado_nxt_s = SUBIENDO;
          else if (bajar) estado_nxt_s = BAJANDO;
          else            estado_nxt_s = PARADA;
        end
        SUBIENDO: begin
          if (bajar) begin
            estado_nxt_s = ESPERA;
            dir_nxt_s    = 1'b0;
          end else if (subir) begin
            estado_nxt_s = SUBIENDO;
          end else begin
            estado_nxt_s = PARADA;
          end
        end
        BAJANDO: begin
          if (subir) begin
            estado_nxt_s = ESPERA;
            dir_nxt_s    = 1'b1;
          end else if (bajar) begin
            estado_nxt_s = BAJANDO;
          end else begin
            estado_nxt_s = PARADA;
          end
        end
        ESPERA: begin
          // Both commands high was handled above, so lat_s high means only the new direction is asked
          if (!lat_s) begin
            estado_nxt_s = PARADA;
          end else if (dead_r == DW'(REV_DEAD - 1)) begin
            estado_nxt_s = dir_r ? SUBIENDO : BAJANDO;
          end else begin
            estado_nxt_s = ESPERA;
            dead_nxt_s   = dead_r + DW'(1);
          end
        end
        FALLA: begin
          if (!subir && !bajar) estado_nxt_s = PARADA;
          else                  estado_nxt_s = FALLA;
        end
        default: begin
          estado_nxt_s = PARADA;
        end
      endcase
    end
  end

  // Position step on tick, saturating at both ends; an illegal command freezes it
  always_comb begin
    pos_nxt_s = pos_r;
    if (tick_s && !ambos_s) begin
      if ((estado_r == SUBIENDO) && (pos_r != TOPE))     pos_nxt_s = pos_r + POS_W'(1);
      else if ((estado_r == BAJANDO) && (pos_r != CERO)) pos_nxt_s = pos_r - POS_W'(1);
      else                                               pos_nxt_s = pos_r;
    end else begin
      pos_nxt_s = pos_r;
    end
  end

  assign moving_nxt_s = ((estado_nxt_s == SUBIENDO) && (pos_nxt_s != TOPE)) ||
                        ((estado_nxt_s == BAJANDO)  && (pos_nxt_s != CERO));

`ifdef PERSIANA_REBOTE_EN
  logic [1:0] fase_sup_r, fase_inf_r, fase_sup_nxt_s, fase_inf_nxt_s;

  // Bounce phase starts on arrival at a limit and runs REBOTE_LEN cycles
  always_comb begin
    fase_sup_nxt_s = 2'd0;
    fase_inf_nxt_s = 2'd0;
    if (pos_nxt_s != TOPE)                                        fase_sup_nxt_s = 2'd0;
    else if (pos_r != TOPE)                                       fase_sup_nxt_s = 2'd1;
    else if ((fase_sup_r != 2'd0) && (fase_sup_r < 2'(REBOTE_LEN))) fase_sup_nxt_s = fase_sup_r + 2'd1;
    else                                                          fase_sup_nxt_s = 2'd0;
    if (pos_nxt_s != CERO)                                        fase_inf_nxt_s = 2'd0;
    else if (pos_r != CERO)                                       fase_inf_nxt_s = 2'd1;
    else if ((fase_inf_r != 2'd0) && (fase_inf_r < 2'(REBOTE_LEN))) fase_inf_nxt_s = fase_inf_r + 2'd1;
    else                                                          fase_inf_nxt_s = 2'd0;
  end

  // Bounce phase registers
  always_ff @(posedge Reloj or negedge reset) begin
    if (!reset) begin
      fase_sup_r <= 2'd0;
      fase_inf_r <= 2'd0;
    end else begin
      fase_sup_r <= fase_sup_nxt_s;
      fase_inf_r <= fase_inf_nxt_s;
    end
  end

  assign ssup_nxt_s = (pos_nxt_s == TOPE) & rebote_nivel(fase_sup_nxt_s);
  assign sinf_nxt_s = (pos_nxt_s == CERO) & rebote_nivel(fase_inf_nxt_s);
`else
  assign ssup_nxt_s = (pos_nxt_s == TOPE);
  assign sinf_nxt_s = (pos_nxt_s == CERO);
`endif

  // State, position and output registers; sensors are decoded from the next position so they track pos
  always_ff @(posedge Reloj or negedge reset) begin
    if (!reset) begin
      estado_r <= PARADA;
      dir_r    <= 1'b0;
      dead_r   <= DW'(0);
      pos_r    <= INI;
      moving_r <= 1'b0;
      fault_r  <= 1'b0;
      ssup_r   <= (INI == TOPE);
      smed_r   <= (INI == MEDIO);
      sinf_r   <= (INI == CERO);
    end else begin
      estado_r <= estado_nxt_s;
      dir_r    <= dir_nxt_s;
      dead_r   <= dead_nxt_s;
      pos_r    <= pos_nxt_s;
      moving_r <= moving_nxt_s;
      fault_r  <= (estado_nxt_s == FALLA);
      ssup_r   <= ssup_nxt_s;
      smed_r   <= (pos_nxt_s == MEDIO);
      sinf_r   <= sinf_nxt_s;
    end
  end

  assign pos    = pos_r;
  assign moving = moving_r;
  assign fault  = fault_r;
  assign Ssup   = ssup_r;
  assign Smed   = smed_r;
  assign Sinf   = sinf_r;

endmodule
